regfile_dump: RTL and testbench
===============================

# regfile_dump

Parametrised MIPS register file: two asynchronous read ports, one synchronous write port, optional hardwired-zero register and optional write-to-read bypass. Adds a handshake-driven dump engine that streams every register out in address order so a bench or debug host can capture full architectural state. Sits in the datapath between instruction decode (read and write addresses) and the ALU/writeback mux (`wd3`).

## Interface
- `DATA_WIDTH`, 32, register width in bits
- `ADDR_WIDTH`, 5, address width; DEPTH = 2**ADDR_WIDTH registers
- `ZERO_REG`, 1, when 1 register 0 reads as 0 and ignores writes
- `BYPASS`, 1, when 1 a read of the address being written this cycle returns `wd3`

- `clk`  in  1  sole clock, rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `we3`  in  1  write enable from controller
- `a1`, `a2`  in  ADDR_WIDTH  read addresses
- `a3`  in  ADDR_WIDTH  write address
- `wd3`  in  DATA_WIDTH  write data
- `rd1`, `rd2`  out  DATA_WIDTH  read data, combinational
- `dump_start`  in  1  request full dump; sampled in IDLE only
- `dump_ready`  in  1  consumer accepts current beat
- `dump_valid`  out  1  beat valid
- `dump_addr`  out  ADDR_WIDTH  address of current beat
- `dump_data`  out  DATA_WIDTH  contents of `dump_addr`
- `dump_busy`  out  1  engine not IDLE
- `dump_done`  out  1  one-cycle pulse after last beat accepted

## Operation
- Write: on rising `clk` with `rst_n`=1 and `we3`=1, mem[a3] <= wd3. If ZERO_REG=1 and a3=0, write dropped.
- Read: rdN = mem[aN]; forced 0 when ZERO_REG=1 and aN=0 (regardless of bypass). If BYPASS=1, `we3`=1, aN=a3 (and not the zero register), rdN = wd3.
- Dump FSM, states IDLE, SEND, DONE:
  - IDLE: `dump_start`=1 -> SEND, dump_addr <= 0.
  - SEND: dump_valid=1. On dump_valid & dump_ready: if dump_addr = DEPTH-1 -> DONE, else dump_addr <= dump_addr+1. Without ready, state and address hold.
  - DONE: dump_done=1 for exactly one cycle -> IDLE.
- `dump_busy` = 1 in SEND and DONE. `dump_start` outside IDLE ignored (no queuing).
- `dump_data` is a live read of mem[dump_addr] (same zero-reg rule, no bypass): a write to dump_addr while stalled changes the beat data the next cycle. Writes and reads are never blocked by a dump.
- Address arithmetic: dump_addr counts modulo DEPTH, never wraps within a dump (terminates at DEPTH-1).

## Timing
- Reset (`rst_n`=0 at rising edge): all registers 0, FSM IDLE, dump_addr=0, dump_valid=0, dump_busy=0, dump_done=0. Reset mid-dump aborts with no dump_done. Writes during reset cycle are dropped.
- Write latency: data visible on rdN the cycle after the edge (same cycle with BYPASS=1).
- Dump latency: dump_start at edge N -> dump_valid high in cycle N+1. With dump_ready tied 1, DEPTH beats in cycles N+1..N+DEPTH, dump_done in cycle N+DEPTH+1, busy low from N+DEPTH+2; next dump_start accepted in that cycle.
- dump_done and dump_valid never high together.
- Simultaneous `we3` and `dump_start`: both take effect; the write lands before beat 0 is presented.

## Test plan
- Reset then read: rst_n=0 one edge, a1=0, a2=31 -> rd1=0, rd2=0; all dump outputs 0.
- Write/read: we3=1, a3=25, wd3=11 one edge; then a1=25 -> rd1=11; we3=1, a3=0, wd3=0xDEAD then a1=0 -> rd1=0.
- Bypass: we3=1, a3=8, wd3=0x1234, a2=8 same cycle -> rd2=0x1234 before edge; with BYPASS=0 -> rd2 = old value.
- Full dump: preload mem[i]=i*3 (i=1..31), dump_start pulse, dump_ready=1 -> 32 beats, beat i data i*3 (beat 0 = 0), dump_done pulse exactly 33 cycles after start.
- Backpressure: dump_ready toggled 1/0 each cycle -> addresses 0..31 each accepted once, none skipped or repeated; write mem[addr] while stalled -> beat carries new value.
- Reset mid-dump: rst_n=0 at beat 10 -> dump_valid=0, busy=0, no dump_done; fresh dump_start afterwards restarts at address 0 with all data 0.

Source files
------------

// File: rtl/regfile_dump.sv
// MIPS register file: two asynchronous read ports, one synchronous write port,
// plus a handshake dump engine that streams every register out in address order.
module regfile_dump #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we3,
    input  logic [ADDR_WIDTH-1:0] a1,
    input  logic [ADDR_WIDTH-1:0] a2,
    input  logic [ADDR_WIDTH-1:0] a3,
    input  logic [DATA_WIDTH-1:0] wd3,
    output logic [DATA_WIDTH-1:0] rd1,
    output logic [DATA_WIDTH-1:0] rd2,
    input  logic                  dump_start,
    input  logic                  dump_ready,
    output logic                  dump_valid,
    output logic [ADDR_WIDTH-1:0] dump_addr,
    output logic [DATA_WIDTH-1:0] dump_data,
    output logic                  dump_busy,
    output logic                  dump_done
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        DONE
    } state_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    state_t                state;
    logic                  wr_en;

    assign wr_en = we3 && !((ZERO_REG != 0) && (a3 == '0));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[a3] <= wd3;
        end
    end

    // Zero register wins over bypass; the dump port never bypasses.
    function automatic logic [DATA_WIDTH-1:0] read_port(
        input logic [ADDR_WIDTH-1:0] addr,
        input logic                  bypass_en,
        input logic                  wr,
        input logic [ADDR_WIDTH-1:0] waddr,
        input logic [DATA_WIDTH-1:0] wdata,
        input logic [DATA_WIDTH-1:0] stored
    );
        logic [DATA_WIDTH-1:0] value;
        value = stored;
        if ((ZERO_REG != 0) && (addr == '0)) begin
            value = '0;
        end else if (bypass_en && wr && (addr == waddr)) begin
            value = wdata;
        end
        return value;
    endfunction

    always_comb begin
        rd1       = read_port(a1, BYPASS != 0, we3, a3, wd3, mem[a1]);
        rd2       = read_port(a2, BYPASS != 0, we3, a3, wd3, mem[a2]);
        dump_data = read_port(dump_addr, 1'b0, we3, a3, wd3, mem[dump_addr]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            dump_addr  <= '0;
            dump_valid <= 1'b0;
            dump_busy  <= 1'b0;
            dump_done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (dump_start) begin
                        state      <= SEND;
                        dump_addr  <= '0;
                        dump_valid <= 1'b1;
                        dump_busy  <= 1'b1;
                    end
                end
                SEND: begin
                    if (dump_ready) begin
                        if (dump_addr == LAST_ADDR) begin
                            state      <= DONE;
                            dump_valid <= 1'b0;
                            dump_done  <= 1'b1;
                        end else begin
                            dump_addr <= dump_addr + ADDR_WIDTH'(1);
                        end
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    dump_done <= 1'b0;
                    dump_busy <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    dump_valid <= 1'b0;
                    dump_busy  <= 1'b0;
                    dump_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dump.sv
// Randomised self-checking bench for regfile_dump against an array model of the
// architectural registers, with a second instance built without bypass.
module tb_regfile_dump;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int DEPTH = 32;

    logic          clk;
    logic          rst_n;
    logic          we3;
    logic [AW-1:0] a1, a2, a3;
    logic [DW-1:0] wd3;
    logic [DW-1:0] rd1, rd2;
    logic          dump_start, dump_ready;
    logic          dump_valid, dump_busy, dump_done;
    logic [AW-1:0] dump_addr;
    logic [DW-1:0] dump_data;

    logic [DW-1:0] rd1b, rd2b, dump_data_b;
    logic          dump_valid_b, dump_busy_b, dump_done_b;
    logic [AW-1:0] dump_addr_b;

    logic [DW-1:0] model [DEPTH];
    int            passed;
    int            total;

    regfile_dump #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(1), .BYPASS(1)) dut (
        .clk(clk), .rst_n(rst_n), .we3(we3), .a1(a1), .a2(a2), .a3(a3), .wd3(wd3),
        .rd1(rd1), .rd2(rd2), .dump_start(dump_start), .dump_ready(dump_ready),
        .dump_valid(dump_valid), .dump_addr(dump_addr), .dump_data(dump_data),
        .dump_busy(dump_busy), .dump_done(dump_done)
    );

    regfile_dump #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(1), .BYPASS(0)) dut_nobyp (
        .clk(clk), .rst_n(rst_n), .we3(we3), .a1(a1), .a2(a2), .a3(a3), .wd3(wd3),
        .rd1(rd1b), .rd2(rd2b), .dump_start(dump_start), .dump_ready(dump_ready),
        .dump_valid(dump_valid_b), .dump_addr(dump_addr_b), .dump_data(dump_data_b),
        .dump_busy(dump_busy_b), .dump_done(dump_done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Registers change only at an edge with reset released; register 0 never changes.
    task automatic commit_write();
        if (rst_n && we3 && a3 != 0) model[a3] = wd3;
    endtask

    function automatic logic [DW-1:0] expect_rd(input logic [AW-1:0] addr, input bit bypass_en);
        if (addr == 0) return '0;
        if (bypass_en && we3 && addr == a3) return wd3;
        return model[addr];
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; we3 = 1'b1; a3 = 5'd5; wd3 = $urandom;
        dump_start = 1'b0; dump_ready = 1'b0; a1 = '0; a2 = 5'd31;
        tick();
        tick();
        rst_n = 1'b1; we3 = 1'b0;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        #1;
        total++;
        if (rd1 !== 32'd0 || rd2 !== 32'd0)
            $display("FAIL reset_read: rd1=%h rd2=%h expected 0 0", rd1, rd2);
        else passed++;
        total++;
        if ({dump_valid, dump_busy, dump_done} !== 3'b000 || dump_addr !== 5'd0)
            $display("FAIL reset_dump_outputs: valid=%b busy=%b done=%b addr=%0d expected all 0",
                     dump_valid, dump_busy, dump_done, dump_addr);
        else passed++;
        for (int i = 0; i < DEPTH; i++) begin
            a1 = 5'(i);
            #1;
            total++;
            if (rd1 !== 32'd0) $display("FAIL reset_reg%0d: got %h expected 0", i, rd1);
            else passed++;
        end
    endtask

    task automatic test_write_read();
        we3 = 1'b1; a3 = 5'd25; wd3 = 32'd11;
        tick(); commit_write();
        we3 = 1'b0; a1 = 5'd25;
        #1;
        total++;
        if (rd1 !== 32'd11) $display("FAIL write_read_25: got %h expected %h", rd1, 32'd11);
        else passed++;
        we3 = 1'b1; a3 = 5'd0; wd3 = 32'hDEAD; a1 = 5'd0;
        #1;
        total++;
        if (rd1 !== 32'd0) $display("FAIL zero_reg_bypass: got %h expected 0", rd1);
        else passed++;
        tick(); commit_write();
        we3 = 1'b0;
        #1;
        total++;
        if (rd1 !== 32'd0) $display("FAIL zero_reg_write: got %h expected 0", rd1);
        else passed++;
        for (int n = 0; n < 60; n++) begin
            we3 = 1'($urandom_range(0, 1));
            a3  = 5'($urandom);
            wd3 = $urandom;
            a1  = ($urandom_range(0, 3) == 0) ? a3 : 5'($urandom);
            a2  = ($urandom_range(0, 3) == 0) ? a3 : 5'($urandom);
            #1;
            total++;
            if (rd1 !== expect_rd(a1, 1'b1) || rd2 !== expect_rd(a2, 1'b1))
                $display("FAIL rand_read_byp a1=%0d a2=%0d: got %h %h expected %h %h",
                         a1, a2, rd1, rd2, expect_rd(a1, 1'b1), expect_rd(a2, 1'b1));
            else passed++;
            total++;
            if (rd1b !== expect_rd(a1, 1'b0) || rd2b !== expect_rd(a2, 1'b0))
                $display("FAIL rand_read_nobyp a1=%0d a2=%0d: got %h %h expected %h %h",
                         a1, a2, rd1b, rd2b, expect_rd(a1, 1'b0), expect_rd(a2, 1'b0));
            else passed++;
            tick(); commit_write();
        end
        we3 = 1'b0;
    endtask

    task automatic test_bypass();
        we3 = 1'b1; a3 = 5'd8; wd3 = 32'h55;
        tick(); commit_write();
        wd3 = 32'h1234; a2 = 5'd8;
        #1;
        total++;
        if (rd2 !== 32'h1234) $display("FAIL bypass_on: got %h expected %h", rd2, 32'h1234);
        else passed++;
        total++;
        if (rd2b !== 32'h55) $display("FAIL bypass_off: got %h expected %h", rd2b, 32'h55);
        else passed++;
        tick(); commit_write();
        we3 = 1'b0;
        #1;
        total++;
        if (rd2b !== 32'h1234) $display("FAIL bypass_off_after: got %h expected %h", rd2b, 32'h1234);
        else passed++;
    endtask

    // Starts a dump (any write already set up lands with the start edge) and follows it
    // to completion, checking every presented beat against the model.
    task automatic run_dump(input bit toggle, input int stall_addr,
                            output int beats, output int done_k, output int done_cnt,
                            output bit wrote);
        int exp_addr;
        dump_start = 1'b1;
        dump_ready = 1'b1;
        #1;
        tick(); commit_write();
        we3 = 1'b0; dump_start = 1'b0;
        exp_addr = 0; beats = 0; done_k = 0; done_cnt = 0; wrote = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            dump_ready = toggle ? (k % 2 == 1) : 1'b1;
            dump_start = toggle ? 1'($urandom_range(0, 1)) : 1'b0;
            we3 = 1'b0;
            if (stall_addr > 0 && !wrote && exp_addr == stall_addr && !dump_ready) begin
                we3 = 1'b1; a3 = 5'(exp_addr); wd3 = $urandom; wrote = 1'b1;
            end
            #1;
            total++;
            if (dump_valid && dump_done)
                $display("FAIL valid_done_overlap: cycle %0d valid=1 done=1 expected not both", k);
            else passed++;
            if (dump_done) begin
                done_cnt++;
                if (done_k == 0) done_k = k;
            end
            if (dump_valid) begin
                total++;
                if (dump_addr !== 5'(exp_addr) || dump_data !== expect_rd(5'(exp_addr), 1'b0))
                    $display("FAIL beat cycle %0d: addr=%0d data=%h expected addr=%0d data=%h",
                             k, dump_addr, dump_data, exp_addr, expect_rd(5'(exp_addr), 1'b0));
                else passed++;
                if (dump_ready) begin
                    exp_addr++;
                    beats++;
                end
            end
            tick(); commit_write();
            we3 = 1'b0;
            if (done_k != 0) break;
        end
        dump_start = 1'b0;
        dump_ready = 1'b0;
    endtask

    task automatic test_full_dump();
        int  beats, done_k, done_cnt;
        bit  wrote;
        for (int i = 2; i < DEPTH; i++) begin
            we3 = 1'b1; a3 = 5'(i); wd3 = 32'(i * 3);
            tick(); commit_write();
        end
        we3 = 1'b1; a3 = 5'd1; wd3 = 32'd3;
        run_dump(1'b0, 0, beats, done_k, done_cnt, wrote);
        total++;
        if (beats != 32 || done_cnt != 1 || done_k != 33)
            $display("FAIL full_dump: beats=%0d dones=%0d done_cycle=%0d expected 32 1 33",
                     beats, done_cnt, done_k);
        else passed++;
        #1;
        total++;
        if (dump_busy !== 1'b0 || dump_valid !== 1'b0)
            $display("FAIL idle_after_done: busy=%b valid=%b expected 0 0", dump_busy, dump_valid);
        else passed++;
        // back-to-back: start accepted in the first cycle busy is low
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        #1;
        total++;
        if (dump_valid !== 1'b1 || dump_addr !== 5'd0 || dump_data !== 32'd0)
            $display("FAIL back_to_back: valid=%b addr=%0d data=%h expected 1 0 0",
                     dump_valid, dump_addr, dump_data);
        else passed++;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
    endtask

    task automatic test_backpressure();
        int  beats, done_k, done_cnt;
        bit  wrote;
        for (int i = 1; i < DEPTH; i++) begin
            we3 = 1'b1; a3 = 5'(i); wd3 = $urandom;
            tick(); commit_write();
        end
        we3 = 1'b0;
        run_dump(1'b1, 5, beats, done_k, done_cnt, wrote);
        total++;
        if (beats != 32 || done_cnt != 1 || done_k != 64 || !wrote)
            $display("FAIL backpressure: beats=%0d dones=%0d done_cycle=%0d wrote=%0b expected 32 1 64 1",
                     beats, done_cnt, done_k, wrote);
        else passed++;
        #1;
        total++;
        if (dump_busy !== 1'b0 || dump_valid !== 1'b0)
            $display("FAIL start_not_queued: busy=%b valid=%b expected 0 0", dump_busy, dump_valid);
        else passed++;
    endtask

    task automatic test_reset_mid_dump();
        int  beats, done_k, done_cnt;
        bit  wrote;
        bit  saw_bad;
        dump_ready = 1'b1;
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        for (int k = 1; k <= 10; k++) tick();
        total++;
        if (dump_valid !== 1'b1 || dump_addr !== 5'd10)
            $display("FAIL beat10_reached: valid=%b addr=%0d expected 1 10", dump_valid, dump_addr);
        else passed++;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        dump_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        #1;
        total++;
        if ({dump_valid, dump_busy, dump_done} !== 3'b000 || dump_addr !== 5'd0)
            $display("FAIL mid_dump_reset: valid=%b busy=%b done=%b addr=%0d expected all 0",
                     dump_valid, dump_busy, dump_done, dump_addr);
        else passed++;
        saw_bad = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (dump_done || dump_busy) saw_bad = 1'b1;
            tick();
        end
        total++;
        if (saw_bad) $display("FAIL no_done_after_abort: got done/busy high expected low");
        else passed++;
        a1 = 5'd17;
        #1;
        total++;
        if (rd1 !== 32'd0) $display("FAIL reg_cleared: got %h expected 0", rd1);
        else passed++;
        run_dump(1'b0, 0, beats, done_k, done_cnt, wrote);
        total++;
        if (beats != 32 || done_cnt != 1 || done_k != 33)
            $display("FAIL restart_dump: beats=%0d dones=%0d done_cycle=%0d expected 32 1 33",
                     beats, done_cnt, done_k);
        else passed++;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rst_n = 1'b0; we3 = 1'b0; a1 = '0; a2 = '0; a3 = '0; wd3 = '0;
        dump_start = 1'b0; dump_ready = 1'b0;
        test_reset();
        test_write_read();
        test_bypass();
        test_full_dump();
        test_backpressure();
        test_reset_mid_dump();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
